// File: rtl/apb_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// apb_irq_ctrl_pkg
// Shared definitions for the APB interrupt controller:
//   - byte offsets of the programmer-visible registers
//   - delivery FSM state encoding
//   - highest-set-index priority encoder
// No ports (package).
// -----------------------------------------------------------------------------
package apb_irq_ctrl_pkg;

  // Widest source vector the controller supports; narrower builds zero-extend.
  localparam int unsigned MAX_IRQ = 32;

  // Register byte offsets (compared against PADDR[4:0]).
  localparam logic [4:0] OFF_MASK     = 5'h00;
  localparam logic [4:0] OFF_MODE     = 5'h04;
  localparam logic [4:0] OFF_PEND     = 5'h08;
  localparam logic [4:0] OFF_PEND_CLR = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  // Highest byte address that decodes to a register.
  localparam logic [31:0] LAST_OFFSET = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } irq_state_e;

  // Index of the highest set bit; 0 when the vector is empty (callers
  // only use the result when at least one bit is set).
  function automatic logic [4:0] hi_index(input logic [MAX_IRQ-1:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (vec[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/apb_irq_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// One interrupt source: SYNC_STAGES-deep synchroniser followed by a delay
// flop used for rising-edge detection.
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   src_i        raw asynchronous event line
//   edge_mode_i  1 = rising-edge source, 0 = level source
//   set_o        request to set the pending bit this cycle
// -----------------------------------------------------------------------------
module irq_sync_edge
  import apb_irq_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic src_i,
  input  logic edge_mode_i,
  output logic set_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  logic                   synced_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  // Shift-register next state for the synchroniser chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = src_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser and edge-detect delay flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= synced_s;
    end
  end

  // Edge sources set once per rise; level sources keep setting while high.
  always_comb begin
    if (edge_mode_i) begin
      set_o = synced_s & ~dly_q;
    end else begin
      set_o = synced_s;
    end
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// apb_irq_ctrl
// APB interrupt controller: latches N_IRQ event lines as pending (edge or
// level per line), masks them, picks the highest active index and hands it
// to the core through an irq / irq_id / ack handshake.
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   PADDR..PSLVERR           APB slave (zero wait state)
//   irq_src_i[N_IRQ]         raw asynchronous event lines
//   irq_o, irq_id_o          request and id presented to the core
//   irq_ack_i, irq_ack_id_i  single-cycle acknowledge with id
// Register map (byte offsets): 0x00 MASK, 0x04 MODE, 0x08 PEND (W1S),
// 0x0C PEND_CLR (W1C), 0x10 STATUS {irq_o, .., irq_id_o}.
// -----------------------------------------------------------------------------
module apb_irq_ctrl
  import apb_irq_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ          = 32,
  parameter int unsigned ID_WIDTH       = 5,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [N_IRQ-1:0]          irq_src_i,
  output logic                      irq_o,
  output logic [ID_WIDTH-1:0]       irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [ID_WIDTH-1:0]       irq_ack_id_i
);

  // Programmer-visible state
  logic [N_IRQ-1:0]    mask_q, mask_d;
  logic [N_IRQ-1:0]    mode_q, mode_d;
  logic [N_IRQ-1:0]    pend_q, pend_d;

  // Delivery FSM state and registered outputs
  irq_state_e          state_q;
  logic                irq_q;
  logic [ID_WIDTH-1:0] irq_id_q;

  // APB decode
  logic                acc_s;
  logic                addr_err_s;
  logic                wr_s;
  logic                rd_s;
  logic [N_IRQ-1:0]    wdata_s;
  logic [31:0]         rdata_s;

  // Pending update terms
  logic [N_IRQ-1:0]    hw_set_s;
  logic [N_IRQ-1:0]    sw_set_s;
  logic [N_IRQ-1:0]    sw_clr_s;
  logic [31:0]         ack_clr32_s;
  logic [N_IRQ-1:0]    ack_clr_s;

  // Priority / delivery helpers
  logic [N_IRQ-1:0]    active_s;
  logic [31:0]         act32_s;
  logic [4:0]          cur_idx_s;
  logic                cur_active_s;
  logic                ack_hit_s;

  // ---------------------------------------------------------------------------
  // Input path: one synchroniser/edge detector per source
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_IRQ; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clock       (clock),
      .reset       (reset),
      .src_i       (irq_src_i[g]),
      .edge_mode_i (mode_q[g]),
      .set_o       (hw_set_s[g])
    );
  end

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  // Anything past STATUS or not word aligned is an error and never commits.
  assign acc_s      = PSEL & PENABLE;
  assign addr_err_s = (32'(PADDR) > LAST_OFFSET) | (PADDR[1:0] != 2'b00);
  assign wr_s       = acc_s & PWRITE & ~addr_err_s;
  assign rd_s       = PSEL & ~PWRITE & ~addr_err_s;
  assign wdata_s    = PWDATA[N_IRQ-1:0];

  assign PREADY  = 1'b1;
  assign PSLVERR = acc_s & addr_err_s;
  assign PRDATA  = rdata_s;

  // Combinational read mux; unimplemented upper bits read as zero.
  always_comb begin
    rdata_s = 32'd0;
    if (rd_s) begin
      case (PADDR[4:0])
        OFF_MASK:     rdata_s[N_IRQ-1:0] = mask_q;
        OFF_MODE:     rdata_s[N_IRQ-1:0] = mode_q;
        OFF_PEND:     rdata_s[N_IRQ-1:0] = pend_q;
        OFF_PEND_CLR: rdata_s            = 32'd0;
        OFF_STATUS: begin
          rdata_s[31]           = irq_q;
          rdata_s[ID_WIDTH-1:0] = irq_id_q;
        end
        default:      rdata_s            = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register next state
  // ---------------------------------------------------------------------------
  // Software writes to MASK/MODE and the W1S/W1C pending ports.
  always_comb begin
    mask_d   = mask_q;
    mode_d   = mode_q;
    sw_set_s = '0;
    sw_clr_s = '0;
    if (wr_s) begin
      case (PADDR[4:0])
        OFF_MASK:     mask_d   = wdata_s;
        OFF_MODE:     mode_d   = wdata_s;
        OFF_PEND:     sw_set_s = wdata_s;
        OFF_PEND_CLR: sw_clr_s = wdata_s;
        default:      sw_set_s = '0;
      endcase
    end else begin
      sw_set_s = '0;
    end
  end

  // The acknowledged id clears its own pending bit.
  always_comb begin
    ack_clr32_s = 32'd0;
    if (ack_hit_s) begin
      ack_clr32_s[cur_idx_s] = 1'b1;
    end else begin
      ack_clr32_s = 32'd0;
    end
  end

  assign ack_clr_s = ack_clr32_s[N_IRQ-1:0];

  // Set terms are OR-ed in after the clear so a same-cycle set always wins.
  assign pend_d = (pend_q & ~(sw_clr_s | ack_clr_s)) | hw_set_s | sw_set_s;

  // MASK, MODE and PEND registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority and delivery
  // ---------------------------------------------------------------------------
  assign active_s = pend_q & mask_q;

  // Zero-extend the active vector to the encoder's fixed width.
  always_comb begin
    act32_s              = 32'd0;
    act32_s[N_IRQ-1:0]   = active_s;
  end

  assign cur_idx_s    = 5'(irq_id_q);
  assign cur_active_s = act32_s[cur_idx_s];
  assign ack_hit_s    = (state_q == ST_REQ) & irq_ack_i & (irq_ack_id_i == irq_id_q);

  // Delivery FSM: the id is captured in IDLE and stays frozen until the
  // request is acknowledged or its line stops being active.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|active_s) begin
            irq_id_q <= ID_WIDTH'(hi_index(act32_s));
            irq_q    <= 1'b1;
            state_q  <= ST_REQ;
          end else begin
            irq_q    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_hit_s) begin
            irq_q   <= 1'b0;
            state_q <= ST_GAP;
          end else if (!cur_active_s) begin
            irq_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            irq_q   <= 1'b1;
          end
        end
        ST_GAP: begin
          irq_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_irq_ctrl
// Self-checking bench for apb_irq_ctrl. APB read data and delivered interrupt
// ids are predicted into queues when stimulus is driven and compared when
// the DUT produces them.
// -----------------------------------------------------------------------------
module tb_apb_irq_ctrl;

  localparam int unsigned N_IRQ    = 32;
  localparam int unsigned ID_WIDTH = 5;
  localparam int unsigned AW       = 12;

  logic                clock;
  logic                reset;
  logic [AW-1:0]       PADDR;
  logic [31:0]         PWDATA;
  logic                PWRITE;
  logic                PSEL;
  logic                PENABLE;
  logic [31:0]         PRDATA;
  logic                PREADY;
  logic                PSLVERR;
  logic [N_IRQ-1:0]    irq_src_i;
  logic                irq_o;
  logic [ID_WIDTH-1:0] irq_id_o;
  logic                irq_ack_i;
  logic [ID_WIDTH-1:0] irq_ack_id_i;

  int n_checks;
  int n_fail;

  logic [31:0] rd_exp_q[$];
  logic [31:0] irq_exp_q[$];

  apb_irq_ctrl #(
    .N_IRQ          (N_IRQ),
    .ID_WIDTH       (ID_WIDTH),
    .SYNC_STAGES    (2),
    .APB_ADDR_WIDTH (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .irq_src_i    (irq_src_i),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o),
    .irq_ack_i    (irq_ack_i),
    .irq_ack_id_i (irq_ack_id_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apb_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic exp_err);
    PADDR   = addr;
    PWDATA  = data;
    PWRITE  = 1'b1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #1;
    check_val("pslverr_wr", 32'(PSLVERR), 32'(exp_err));
    tick();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic apb_read(input string tag, input logic [AW-1:0] addr,
                          input logic [31:0] exp, input logic exp_err);
    rd_exp_q.push_back(exp);
    PADDR   = addr;
    PWRITE  = 1'b0;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #1;
    check_val(tag, PRDATA, rd_exp_q.pop_front());
    check_val("pslverr_rd", 32'(PSLVERR), 32'(exp_err));
    check_val("pready", 32'(PREADY), 32'd1);
    tick();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 20 && !irq_o; i++) begin
      tick();
    end
    check_val(tag, 32'(irq_o), 32'd1);
  endtask

  task automatic ack(input logic [ID_WIDTH-1:0] id);
    irq_ack_i    = 1'b1;
    irq_ack_id_i = id;
    tick();
    irq_ack_i    = 1'b0;
    irq_ack_id_i = '0;
  endtask

  // Every rising edge of irq_o must match the next predicted id.
  initial begin
    logic        prev;
    logic [31:0] exp;
    prev = 1'b0;
    forever begin
      @(posedge clock);
      #3;
      if (irq_o && !prev) begin
        exp = (irq_exp_q.size() > 0) ? irq_exp_q.pop_front() : 32'hFFFF_FFFF;
        check_val("irq_id", 32'(irq_id_o), exp);
      end
      prev = irq_o;
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    PADDR        = '0;
    PWDATA       = 32'd0;
    PWRITE       = 1'b0;
    PSEL         = 1'b0;
    PENABLE      = 1'b0;
    irq_src_i    = '0;
    irq_ack_i    = 1'b0;
    irq_ack_id_i = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_irq", 32'(irq_o), 32'd0);
    check_val("rst_id", 32'(irq_id_o), 32'd0);
    check_val("rst_prdata", PRDATA, 32'd0);
    check_val("rst_pslverr", 32'(PSLVERR), 32'd0);
    apb_read("rst_mask",   12'h000, 32'd0, 1'b0);
    apb_read("rst_mode",   12'h004, 32'd0, 1'b0);
    apb_read("rst_pend",   12'h008, 32'd0, 1'b0);
    apb_read("rst_pclr",   12'h00C, 32'd0, 1'b0);
    apb_read("rst_status", 12'h010, 32'd0, 1'b0);

    // Single edge source: exact latency, then ack
    apb_write(12'h000, 32'h0000_0300, 1'b0);
    apb_write(12'h004, 32'h0000_0300, 1'b0);
    irq_exp_q.push_back(32'd8);
    irq_src_i[8] = 1'b1;
    tick();
    irq_src_i[8] = 1'b0;
    check_val("lat_c1", 32'(irq_o), 32'd0);
    tick();
    check_val("lat_c2", 32'(irq_o), 32'd0);
    tick();
    check_val("lat_c3", 32'(irq_o), 32'd0);
    tick();
    check_val("lat_c4", 32'(irq_o), 32'd1);
    check_val("lat_id", 32'(irq_id_o), 32'd8);
    ack(5'd8);
    check_val("ack_drop", 32'(irq_o), 32'd0);
    apb_read("pend_after_ack", 12'h008, 32'd0, 1'b0);

    // Two edge sources together: highest index first, 2-cycle gap
    irq_exp_q.push_back(32'd9);
    irq_exp_q.push_back(32'd8);
    irq_src_i[9:8] = 2'b11;
    tick();
    irq_src_i[9:8] = 2'b00;
    wait_irq("prio_first");
    check_val("prio_first_id", 32'(irq_id_o), 32'd9);
    ack(5'd9);
    check_val("gap_c1", 32'(irq_o), 32'd0);
    tick();
    check_val("gap_c2", 32'(irq_o), 32'd0);
    tick();
    check_val("prio_second", 32'(irq_o), 32'd1);
    check_val("prio_second_id", 32'(irq_id_o), 32'd8);
    ack(5'd8);

    // Level source held high re-requests after ack
    apb_write(12'h000, 32'h0000_0308, 1'b0);
    irq_exp_q.push_back(32'd3);
    irq_src_i[3] = 1'b1;
    wait_irq("level_req");
    ack(5'd3);
    irq_exp_q.push_back(32'd3);
    apb_read("level_pend_reset", 12'h008, 32'h0000_0008, 1'b0);
    wait_irq("level_rereq");
    check_val("level_rereq_id", 32'(irq_id_o), 32'd3);
    irq_src_i[3] = 1'b0;
    repeat (5) tick();
    check_val("level_held", 32'(irq_o), 32'd1);
    ack(5'd3);
    check_val("level_ack_drop", 32'(irq_o), 32'd0);
    repeat (6) tick();
    check_val("level_no_rereq", 32'(irq_o), 32'd0);
    apb_read("level_pend_clr", 12'h008, 32'd0, 1'b0);

    // Wrong-id ack ignored; APB clear of the frozen line withdraws the request
    apb_write(12'h004, 32'h0000_0320, 1'b0);
    apb_write(12'h000, 32'h0000_0320, 1'b0);
    irq_exp_q.push_back(32'd5);
    irq_src_i[5] = 1'b1;
    tick();
    irq_src_i[5] = 1'b0;
    wait_irq("req5");
    ack(5'd4);
    check_val("bad_ack_irq", 32'(irq_o), 32'd1);
    check_val("bad_ack_id", 32'(irq_id_o), 32'd5);
    apb_read("status_req", 12'h010, 32'h8000_0005, 1'b0);
    apb_write(12'h00C, 32'h0000_0020, 1'b0);
    tick();
    check_val("clr_drop", 32'(irq_o), 32'd0);
    tick();
    check_val("clr_idle", 32'(irq_o), 32'd0);
    apb_read("status_idle", 12'h010, 32'h0000_0005, 1'b0);

    // Error accesses have no effect
    apb_write(12'h014, 32'hFFFF_FFFF, 1'b1);
    apb_write(12'h001, 32'hFFFF_FFFF, 1'b1);
    apb_read("err_rd", 12'h014, 32'd0, 1'b1);
    apb_read("err_mask", 12'h000, 32'h0000_0320, 1'b0);
    apb_read("err_mode", 12'h004, 32'h0000_0320, 1'b0);
    apb_read("err_pend", 12'h008, 32'd0, 1'b0);

    // PEND_CLR committing in the same cycle as a new edge: set wins
    apb_write(12'h000, 32'd0, 1'b0);
    irq_src_i[8] = 1'b1;
    tick();
    irq_src_i[8] = 1'b0;
    PADDR   = 12'h00C;
    PWDATA  = 32'h0000_0100;
    PWRITE  = 1'b1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    apb_read("set_beats_clr", 12'h008, 32'h0000_0100, 1'b0);
    apb_write(12'h008, 32'h0000_0200, 1'b0);
    apb_read("sw_set", 12'h008, 32'h0000_0300, 1'b0);
    apb_write(12'h00C, 32'h0000_0300, 1'b0);
    apb_read("sw_clr", 12'h008, 32'd0, 1'b0);

    // Reset while a request is outstanding
    apb_write(12'h000, 32'h0000_0100, 1'b0);
    irq_exp_q.push_back(32'd8);
    apb_write(12'h008, 32'h0000_0100, 1'b0);
    wait_irq("sw_trig_req");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("midrst_irq", 32'(irq_o), 32'd0);
    check_val("midrst_id", 32'(irq_id_o), 32'd0);
    apb_read("midrst_mask", 12'h000, 32'd0, 1'b0);
    apb_read("midrst_pend", 12'h008, 32'd0, 1'b0);
    repeat (4) tick();
    check_val("midrst_quiet", 32'(irq_o), 32'd0);

    check_val("irq_queue_empty", 32'(irq_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
